xosera_bus_bridge: RTL and testbench
====================================

XOSERA_BUS_BRIDGE -- requirements
Module: xosera_bus_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 8, host bus data width; only 8 or 16 are legal.
REQ-002 SHALL have parameter REG_NUM_W, default 4, register-number width.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth; legal range 2..3.
REQ-004 SHALL have parameter DTACK_TIMEOUT, default 15, maximum read-wait cycles; legal range 1..255.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports `clk` (in, 1, rising-edge clock) and `reset_n_i` (in, 1, async active-low reset).
REQ-006 SHALL have the following host-side ports:
- `bus_cs_n_i` (in, 1): chip select, active low.
- `bus_rd_nwr_i` (in, 1): 1 = read, 0 = write.
- `bus_addr_i` (in, AW = REG_NUM_W + (DATA_W==8)): register number, plus byte-select LSB in 8-bit mode.
- `bus_data_i` (in, DATA_W): write data.
- `bus_data_o` (out, DATA_W): read data.
- `bus_out_ena_o` (out, 1): data pin output enable.
- `bus_dtack_n_o` (out, 1): DTACK, active low.
REQ-007 SHALL have the following core-side ports:
- `write_strobe_o` (out, 1), `read_strobe_o` (out, 1).
- `reg_num_o` (out, REG_NUM_W).
- `bytesel_o` (out, 1): 0 in 16-bit mode.
- `data_o` (out, DATA_W).
- `rd_data_i` (in, DATA_W), `rd_ack_i` (in, 1).
- `timeout_o` (out, 1): one-cycle pulse.

Function
REQ-010 SHALL pass `bus_cs_n_i`, `bus_rd_nwr_i`, `bus_addr_i` and `bus_data_i` through SYNC_STAGES flops before any use.
REQ-011 SHALL implement the FSM states IDLE, LATCH, READ_WAIT and HOLD.
REQ-012 IDLE -> LATCH SHALL occur when synced CS equals CS_ENABLED.
REQ-013 In LATCH, if synced CS is still enabled, the block SHALL capture address, data and rd_nwr into `reg_num_o`/`bytesel_o`/`data_o`; otherwise (glitch) it SHALL return to IDLE with no strobe.
REQ-014 On a write captured in LATCH, the block SHALL pulse `write_strobe_o` for 1 cycle, assert DTACK and go to HOLD.
REQ-015 On a read captured in LATCH, the block SHALL pulse `read_strobe_o` for 1 cycle, load the timeout counter with DTACK_TIMEOUT, assert `bus_out_ena_o` and go to READ_WAIT.
REQ-016 Strobes SHALL be registered, rising SYNC_STAGES+1 edges after the edge that first samples `bus_cs_n_i` low.
REQ-017 In READ_WAIT, `rd_ack_i`=1 SHALL register `rd_data_i` into `bus_data_o`, assert DTACK and go to HOLD.
REQ-018 In READ_WAIT, when the counter reaches 0 without an ack, the block SHALL drive `bus_data_o` all-ones, pulse `timeout_o`, assert DTACK and go to HOLD.
REQ-019 If `rd_ack_i` and the counter reaching 0 coincide, the ack SHALL win (real data, no `timeout_o`).
REQ-020 In READ_WAIT, synced CS deasserting SHALL abort to IDLE with no DTACK, and `bus_out_ena_o` SHALL drop the same cycle.
REQ-021 In HOLD, DTACK and `bus_out_ena_o` (reads only) SHALL hold until synced CS deasserts, then return to IDLE, deasserting both in that cycle.
REQ-022 `rd_ack_i` SHALL be ignored in every state other than READ_WAIT.
REQ-023 `reg_num_o`, `bytesel_o` and `data_o` SHALL hold their values between transactions.
REQ-024 A new transaction SHALL require passing through IDLE; back-to-back CS without deassertion SHALL be a single transaction.

Reset
REQ-030 Asserting `reset_n_i` SHALL asynchronously force:
- FSM to IDLE;
- all synchronizer flops to their inactive values (CS high, rd_nwr high);
- `bus_dtack_n_o`=1, `bus_out_ena_o`=0;
- `write_strobe_o`=0, `read_strobe_o`=0, `timeout_o`=0;
- `bus_data_o`, `data_o`, `reg_num_o`, `bytesel_o` = 0.
REQ-031 Reset mid-transaction SHALL drop DTACK and the output enable immediately; after release, the block SHALL require a fresh CS assertion seen through IDLE.

Configuration
REQ-040 With macro XOSERA_BUS_DTACK_EN defined, `bus_dtack_n_o` SHALL exist and behave per REQ-014..REQ-021.
REQ-041 Without XOSERA_BUS_DTACK_EN, the `bus_dtack_n_o` port and the timeout counter SHALL be omitted, `timeout_o` SHALL be tied 0, and READ_WAIT SHALL wait for ack or CS deassertion only.

Structure
REQ-050 The xv package SHALL hold CS_ENABLED, RnW_READ and RnW_WRITE, the FSM state enum typedef, and the default parameter constants.
REQ-051 The synchronizer SHALL be a sub-module, xosera_bus_sync, parametrised by width and SYNC_STAGES, with async active-low reset value inputs.

Verification
REQ-060 8-bit write: CS low, addr 5'b01011, data 8'hA5 -> one `write_strobe_o` at edge 3, `reg_num_o`=4'h5, `bytesel_o`=1, `data_o`=8'hA5, DTACK low until CS high.
REQ-061 16-bit read: `rd_ack_i` 4 cycles after `read_strobe_o` with `rd_data_i`=16'h1234 -> `bus_data_o`=16'h1234, DTACK low, `bus_out_ena_o`=1 until CS high.
REQ-062 Timeout: DTACK_TIMEOUT=3 with no ack -> `timeout_o` pulse 3 cycles after `read_strobe_o`, `bus_data_o`=all-ones, DTACK low.
REQ-063 Glitch: CS low for 1 cycle with SYNC_STAGES=2 -> no strobes, DTACK stays high.
REQ-064 Abort and late ack: CS high during READ_WAIT -> IDLE with no DTACK; a later `rd_ack_i` -> no output change.
REQ-065 Reset in HOLD: `reset_n_i` low -> DTACK=1 and `bus_out_ena_o`=0 without waiting for a clock edge.

Source files
------------

// File: rtl/xosera_bus_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : xv (package)
//  Purpose  : Shared constants, FSM state type and default parameters for the
//             Xosera host bus bridge.
//  Revision : 1.0 - initial release
// ============================================================================
package xv;

    // Host bus signal polarities
    localparam logic CS_ENABLED = 1'b0;
    localparam logic RnW_READ   = 1'b1;
    localparam logic RnW_WRITE  = 1'b0;

    // Default configuration
    localparam int DEFAULT_DATA_W        = 8;
    localparam int DEFAULT_REG_NUM_W     = 4;
    localparam int DEFAULT_SYNC_STAGES   = 2;
    localparam int DEFAULT_DTACK_TIMEOUT = 15;

    // Bridge transaction FSM
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LATCH     = 2'd1,
        ST_READ_WAIT = 2'd2,
        ST_HOLD      = 2'd3
    } bus_state_t;

endpackage
`default_nettype wire

// File: rtl/xosera_bus_sync.sv
`default_nettype none
// ============================================================================
//  Module   : xosera_bus_sync
//  Purpose  : Multi-stage synchronizer for asynchronous host bus inputs, with
//             a per-bit reset value supplied by the instantiating block.
//  Revision : 1.0 - initial release
// ============================================================================
module xosera_bus_sync #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n_i,
    input  logic [WIDTH-1:0] rst_val_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_d;

    // Shift the raw inputs one stage deeper every clock
    always_comb begin
        stage_d = {stage_q[SYNC_STAGES-2:0], d_i};
    end

    // Synchronizer flops, reset to the inactive bus levels
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stage_q <= {SYNC_STAGES{rst_val_i}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/xosera_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : xosera_bus_bridge
//  Purpose  : Synchronizes an asynchronous host register bus and turns each
//             chip-select cycle into one registered core read/write strobe,
//             with read-data return and optional DTACK handshake.
//  Options  : XOSERA_BUS_DTACK_EN - provides bus_dtack_n_o plus a read-wait
//             timeout counter; without it timeout_o is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module xosera_bus_bridge
    import xv::*;
#(
    parameter int DATA_W        = DEFAULT_DATA_W,
    parameter int REG_NUM_W     = DEFAULT_REG_NUM_W,
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int DTACK_TIMEOUT = DEFAULT_DTACK_TIMEOUT
) (
    input  logic                                            clk,
    input  logic                                            reset_n_i,
    // host side
    input  logic                                            bus_cs_n_i,
    input  logic                                            bus_rd_nwr_i,
    input  logic [REG_NUM_W + ((DATA_W == 8) ? 1 : 0) - 1:0] bus_addr_i,
    input  logic [DATA_W-1:0]                               bus_data_i,
    output logic [DATA_W-1:0]                               bus_data_o,
    output logic                                            bus_out_ena_o,
`ifdef XOSERA_BUS_DTACK_EN
    output logic                                            bus_dtack_n_o,
`endif
    // core side
    output logic                                            write_strobe_o,
    output logic                                            read_strobe_o,
    output logic [REG_NUM_W-1:0]                            reg_num_o,
    output logic                                            bytesel_o,
    output logic [DATA_W-1:0]                               data_o,
    input  logic [DATA_W-1:0]                               rd_data_i,
    input  logic                                            rd_ack_i,
    output logic                                            timeout_o
);

    localparam int AW = REG_NUM_W + ((DATA_W == 8) ? 1 : 0);
    localparam int SW = 2 + AW + DATA_W;

    // Reject illegal configurations at elaboration
    generate
        if (!(DATA_W == 8 || DATA_W == 16)) begin : g_bad_data_w
            $error("xosera_bus_bridge: DATA_W must be 8 or 16");
        end
        if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
            $error("xosera_bus_bridge: SYNC_STAGES must be 2..3");
        end
        if (DTACK_TIMEOUT < 1 || DTACK_TIMEOUT > 255) begin : g_bad_timeout
            $error("xosera_bus_bridge: DTACK_TIMEOUT must be 1..255");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Input synchronization: CS, RnW, address and data share one chain
    // ------------------------------------------------------------------
    logic [SW-1:0]        w_sync_in;
    logic [SW-1:0]        w_sync_out;
    logic [SW-1:0]        w_sync_rst;
    logic                 w_cs_s;
    logic                 w_rnw_s;
    logic [AW-1:0]        w_addr_s;
    logic [DATA_W-1:0]    w_data_s;
    logic                 w_cs_active;
    logic [REG_NUM_W-1:0] w_lat_reg_num;
    logic                 w_lat_bytesel;

    assign w_sync_in  = {bus_cs_n_i, bus_rd_nwr_i, bus_addr_i, bus_data_i};
    assign w_sync_rst = {~CS_ENABLED, RnW_READ, {(AW + DATA_W){1'b0}}};

    xosera_bus_sync #(
        .WIDTH       (SW),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .rst_val_i (w_sync_rst),
        .d_i       (w_sync_in),
        .q_o       (w_sync_out)
    );

    assign {w_cs_s, w_rnw_s, w_addr_s, w_data_s} = w_sync_out;
    assign w_cs_active = (w_cs_s == CS_ENABLED);

    // In 8-bit mode the address LSB selects the byte of the register
    generate
        if (DATA_W == 8) begin : g_addr_byte
            assign w_lat_reg_num = w_addr_s[AW-1:1];
            assign w_lat_bytesel = w_addr_s[0];
        end else begin : g_addr_word
            assign w_lat_reg_num = w_addr_s;
            assign w_lat_bytesel = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    bus_state_t           state_q, state_d;
    logic                 write_strobe_q, write_strobe_d;
    logic                 read_strobe_q, read_strobe_d;
    logic                 out_ena_q, out_ena_d;
    logic [DATA_W-1:0]    bus_data_q, bus_data_d;
    logic [REG_NUM_W-1:0] reg_num_q, reg_num_d;
    logic                 bytesel_q, bytesel_d;
    logic [DATA_W-1:0]    data_q, data_d;
`ifdef XOSERA_BUS_DTACK_EN
    logic                 dtack_n_q, dtack_n_d;
    logic                 timeout_q, timeout_d;
    logic [7:0]           cnt_q, cnt_d;
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d        = state_q;
        write_strobe_d = 1'b0;
        read_strobe_d  = 1'b0;
        out_ena_d      = out_ena_q;
        bus_data_d     = bus_data_q;
        reg_num_d      = reg_num_q;
        bytesel_d      = bytesel_q;
        data_d         = data_q;
`ifdef XOSERA_BUS_DTACK_EN
        dtack_n_d      = dtack_n_q;
        timeout_d      = 1'b0;
        cnt_d          = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_cs_active) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                // CS must still be active one cycle later, otherwise it was a glitch
                if (w_cs_active) begin
                    reg_num_d = w_lat_reg_num;
                    bytesel_d = w_lat_bytesel;
                    data_d    = w_data_s;
                    case (w_rnw_s)
                        RnW_WRITE: begin
                            write_strobe_d = 1'b1;
`ifdef XOSERA_BUS_DTACK_EN
                            dtack_n_d      = 1'b0;
`endif
                            state_d        = ST_HOLD;
                        end
                        default: begin
                            read_strobe_d = 1'b1;
                            out_ena_d     = 1'b1;
`ifdef XOSERA_BUS_DTACK_EN
                            cnt_d         = 8'(DTACK_TIMEOUT);
`endif
                            state_d       = ST_READ_WAIT;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ_WAIT: begin
                // Host abort beats ack; ack beats timeout
                if (!w_cs_active) begin
                    out_ena_d = 1'b0;
                    state_d   = ST_IDLE;
                end else if (rd_ack_i) begin
                    bus_data_d = rd_data_i;
`ifdef XOSERA_BUS_DTACK_EN
                    dtack_n_d  = 1'b0;
`endif
                    state_d    = ST_HOLD;
                end
`ifdef XOSERA_BUS_DTACK_EN
                else if (cnt_q == 8'd1) begin
                    bus_data_d = '1;
                    timeout_d  = 1'b1;
                    dtack_n_d  = 1'b0;
                    cnt_d      = 8'd0;
                    state_d    = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
`endif
            end
            ST_HOLD: begin
                if (!w_cs_active) begin
                    out_ena_d = 1'b0;
`ifdef XOSERA_BUS_DTACK_EN
                    dtack_n_d = 1'b1;
`endif
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= ST_IDLE;
            write_strobe_q <= 1'b0;
            read_strobe_q  <= 1'b0;
            out_ena_q      <= 1'b0;
            bus_data_q     <= '0;
            reg_num_q      <= '0;
            bytesel_q      <= 1'b0;
            data_q         <= '0;
`ifdef XOSERA_BUS_DTACK_EN
            dtack_n_q      <= 1'b1;
            timeout_q      <= 1'b0;
            cnt_q          <= 8'd0;
`endif
        end else begin
            state_q        <= state_d;
            write_strobe_q <= write_strobe_d;
            read_strobe_q  <= read_strobe_d;
            out_ena_q      <= out_ena_d;
            bus_data_q     <= bus_data_d;
            reg_num_q      <= reg_num_d;
            bytesel_q      <= bytesel_d;
            data_q         <= data_d;
`ifdef XOSERA_BUS_DTACK_EN
            dtack_n_q      <= dtack_n_d;
            timeout_q      <= timeout_d;
            cnt_q          <= cnt_d;
`endif
        end
    end

    assign write_strobe_o = write_strobe_q;
    assign read_strobe_o  = read_strobe_q;
    assign bus_out_ena_o  = out_ena_q;
    assign bus_data_o     = bus_data_q;
    assign reg_num_o      = reg_num_q;
    assign bytesel_o      = bytesel_q;
    assign data_o         = data_q;
`ifdef XOSERA_BUS_DTACK_EN
    assign bus_dtack_n_o  = dtack_n_q;
    assign timeout_o      = timeout_q;
`else
    assign timeout_o      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xosera_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xosera_bus_bridge
//  Purpose  : Self-checking bench for xosera_bus_bridge. Two bridges share one
//             host bus: an 8-bit one with DTACK_TIMEOUT=3 and a 16-bit one
//             with DTACK_TIMEOUT=15. A transaction-level model predicts every
//             output each cycle; directed sequences pin key literal values.
//  Options  : XOSERA_BUS_DTACK_EN - also checks DTACK and the read timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xosera_bus_bridge;

    localparam int S   = 2;
    localparam int TO0 = 3;
    localparam int TO1 = 15;
`ifdef XOSERA_BUS_DTACK_EN
    localparam bit HAS_DTACK = 1'b1;
`else
    localparam bit HAS_DTACK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs_n, rnw, rd_ack;
    logic [4:0]  addr;
    logic [15:0] wdata, rd_data;

    logic [7:0]  d0_bus_data, d0_data;
    logic [15:0] d1_bus_data, d1_data;
    logic        d0_oe, d0_ws, d0_rs, d0_bs, d0_to, d0_dtack;
    logic        d1_oe, d1_ws, d1_rs, d1_bs, d1_to, d1_dtack;
    logic [3:0]  d0_reg, d1_reg;

    int  checks = 0;
    int  errors = 0;
    bit  cmp_on = 1'b0;
    bit  ok;

    always #5 clk = ~clk;

    xosera_bus_bridge #(
        .DATA_W(8), .REG_NUM_W(4), .SYNC_STAGES(S), .DTACK_TIMEOUT(TO0)
    ) u_dut8 (
        .clk(clk), .reset_n_i(reset_n),
        .bus_cs_n_i(cs_n), .bus_rd_nwr_i(rnw), .bus_addr_i(addr),
        .bus_data_i(wdata[7:0]), .bus_data_o(d0_bus_data), .bus_out_ena_o(d0_oe),
`ifdef XOSERA_BUS_DTACK_EN
        .bus_dtack_n_o(d0_dtack),
`endif
        .write_strobe_o(d0_ws), .read_strobe_o(d0_rs), .reg_num_o(d0_reg),
        .bytesel_o(d0_bs), .data_o(d0_data), .rd_data_i(rd_data[7:0]),
        .rd_ack_i(rd_ack), .timeout_o(d0_to)
    );

    xosera_bus_bridge #(
        .DATA_W(16), .REG_NUM_W(4), .SYNC_STAGES(S), .DTACK_TIMEOUT(TO1)
    ) u_dut16 (
        .clk(clk), .reset_n_i(reset_n),
        .bus_cs_n_i(cs_n), .bus_rd_nwr_i(rnw), .bus_addr_i(addr[3:0]),
        .bus_data_i(wdata), .bus_data_o(d1_bus_data), .bus_out_ena_o(d1_oe),
`ifdef XOSERA_BUS_DTACK_EN
        .bus_dtack_n_o(d1_dtack),
`endif
        .write_strobe_o(d1_ws), .read_strobe_o(d1_rs), .reg_num_o(d1_reg),
        .bytesel_o(d1_bs), .data_o(d1_data), .rd_data_i(rd_data),
        .rd_ack_i(rd_ack), .timeout_o(d1_to)
    );

`ifndef XOSERA_BUS_DTACK_EN
    assign d0_dtack = 1'b1;
    assign d1_dtack = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Reference model: host inputs become visible S cycles late; a CS
    // seen twice in a row starts a transaction, which then waits for an
    // ack / timeout (reads) and for CS release.
    // ------------------------------------------------------------------
    bit          p_cs  [S];
    bit          p_rnw [S];
    logic [4:0]  p_addr[S];
    logic [15:0] p_data[S];

    bit          m_pend[2], m_wait[2], m_hold[2];
    int          m_elapsed[2];
    logic        e_ws[2], e_rs[2], e_to[2], e_dtack[2], e_oe[2], e_bs[2];
    logic [15:0] e_rd[2], e_data[2];
    logic [3:0]  e_reg[2];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < S; i++) begin
                p_cs[i] = 1'b1; p_rnw[i] = 1'b1; p_addr[i] = '0; p_data[i] = '0;
            end
            for (int k = 0; k < 2; k++) begin
                m_pend[k] = 0; m_wait[k] = 0; m_hold[k] = 0; m_elapsed[k] = 0;
                e_ws[k] = 0; e_rs[k] = 0; e_to[k] = 0; e_dtack[k] = 1; e_oe[k] = 0;
                e_bs[k] = 0; e_rd[k] = '0; e_data[k] = '0; e_reg[k] = '0;
            end
        end else begin
            bit          scs, srnw;
            logic [4:0]  sa;
            logic [15:0] sd;
            scs = p_cs[S-1]; srnw = p_rnw[S-1]; sa = p_addr[S-1]; sd = p_data[S-1];
            for (int k = 0; k < 2; k++) begin
                int          lim;
                logic [15:0] mask;
                lim  = (k == 0) ? TO0 : TO1;
                mask = (k == 0) ? 16'h00FF : 16'hFFFF;
                e_ws[k] = 0; e_rs[k] = 0; e_to[k] = 0;
                if (m_hold[k]) begin
                    if (scs) begin m_hold[k] = 0; e_dtack[k] = 1; e_oe[k] = 0; end
                end else if (m_wait[k]) begin
                    if (scs) begin
                        m_wait[k] = 0; e_oe[k] = 0;
                    end else if (rd_ack) begin
                        e_rd[k] = rd_data & mask; e_dtack[k] = 0;
                        m_wait[k] = 0; m_hold[k] = 1;
                    end else begin
                        m_elapsed[k] = m_elapsed[k] + 1;
                        if (HAS_DTACK && m_elapsed[k] == lim) begin
                            e_rd[k] = mask; e_to[k] = 1; e_dtack[k] = 0;
                            m_wait[k] = 0; m_hold[k] = 1;
                        end
                    end
                end else if (m_pend[k]) begin
                    m_pend[k] = 0;
                    if (!scs) begin
                        e_reg[k]  = (k == 0) ? sa[4:1] : sa[3:0];
                        e_bs[k]   = (k == 0) ? sa[0] : 1'b0;
                        e_data[k] = sd & mask;
                        if (srnw) begin
                            e_rs[k] = 1; e_oe[k] = 1; m_elapsed[k] = 0; m_wait[k] = 1;
                        end else begin
                            e_ws[k] = 1; e_dtack[k] = 0; m_hold[k] = 1;
                        end
                    end
                end else if (!scs) begin
                    m_pend[k] = 1;
                end
            end
            for (int i = S - 1; i > 0; i--) begin
                p_cs[i] = p_cs[i-1]; p_rnw[i] = p_rnw[i-1];
                p_addr[i] = p_addr[i-1]; p_data[i] = p_data[i-1];
            end
            p_cs[0] = cs_n; p_rnw[0] = rnw; p_addr[0] = addr; p_data[0] = wdata;
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both bridges against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("ws8",   d0_ws,       e_ws[0]);    chk("ws16",   d1_ws,       e_ws[1]);
            chk("rs8",   d0_rs,       e_rs[0]);    chk("rs16",   d1_rs,       e_rs[1]);
            chk("to8",   d0_to,       e_to[0]);    chk("to16",   d1_to,       e_to[1]);
            chk("oe8",   d0_oe,       e_oe[0]);    chk("oe16",   d1_oe,       e_oe[1]);
            chk("rd8",   d0_bus_data, e_rd[0]);    chk("rd16",   d1_bus_data, e_rd[1]);
            chk("reg8",  d0_reg,      e_reg[0]);   chk("reg16",  d1_reg,      e_reg[1]);
            chk("bs8",   d0_bs,       e_bs[0]);    chk("bs16",   d1_bs,       e_bs[1]);
            chk("data8", d0_data,     e_data[0]);  chk("data16", d1_data,     e_data[1]);
`ifdef XOSERA_BUS_DTACK_EN
            chk("dtack8", d0_dtack, e_dtack[0]);   chk("dtack16", d1_dtack, e_dtack[1]);
`endif
        end
    end

    task automatic wait_rs(output bit found);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (d1_rs === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL read_strobe_wait actual=none expected=strobe_within_12_cycles t=%0t", $time);
        end
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b1; cs_n = 1'b1; rnw = 1'b1; rd_ack = 1'b0;
        addr = '0; wdata = '0; rd_data = '0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_dtack8", d0_dtack, 1'b1);  chk("rst_oe8", d0_oe, 1'b0);
        chk("rst_reg8", d0_reg, 4'h0);      chk("rst_rd16", d1_bus_data, 16'h0000);
        chk("rst_ws8", d0_ws, 1'b0);        chk("rst_to8", d0_to, 1'b0);
        cmp_on = 1'b1;
        wait_neg(3);
        reset_n = 1'b1;
        wait_neg(2);

        // 8-bit write: strobe exactly on the third edge after CS is first sampled
        cs_n = 1'b0; rnw = 1'b0; addr = 5'b01011; wdata = 16'h5AA5;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("wr_strobe_edge", d0_ws, (i == 4) ? 16'd1 : 16'd0);
        end
        chk("wr_reg8", d0_reg, 4'h5);       chk("wr_bs8", d0_bs, 1'b1);
        chk("wr_data8", d0_data, 8'hA5);    chk("wr_reg16", d1_reg, 4'hB);
        chk("wr_bs16", d1_bs, 1'b0);        chk("wr_data16", d1_data, 16'h5AA5);
        chk("wr_dtack8", d0_dtack, HAS_DTACK ? 16'd0 : 16'd1);
        wait_neg(3);
        cs_n = 1'b1;
        wait_neg(2);
        chk("wr_dtack_held", d0_dtack, HAS_DTACK ? 16'd0 : 16'd1);
        wait_neg(1);
        chk("wr_dtack_release", d0_dtack, 1'b1);
        wait_neg(2);

        // Read: 16-bit bridge gets an ack 4 cycles after the strobe,
        // the 8-bit bridge (timeout 3) times out one cycle earlier
        cs_n = 1'b0; rnw = 1'b1; addr = 5'b00110; wdata = 16'h0F0F;
        wait_rs(ok);
        chk("rd_oe8", d0_oe, 1'b1);
        wait_neg(2);
        chk("rd_to8_early", d0_to, 1'b0);
        wait_neg(1);
        chk("rd_to8_pulse", d0_to, HAS_DTACK ? 16'd1 : 16'd0);
        chk("rd_to8_data", d0_bus_data, HAS_DTACK ? 16'h00FF : 16'h0000);
        chk("rd_dtack16_wait", d1_dtack, 1'b1);
        rd_ack = 1'b1; rd_data = 16'h1234;
        wait_neg(1);
        rd_ack = 1'b0;
        chk("rd_data16", d1_bus_data, 16'h1234);
        chk("rd_dtack16", d1_dtack, HAS_DTACK ? 16'd0 : 16'd1);
        chk("rd_oe16", d1_oe, 1'b1);        chk("rd_to16", d1_to, 1'b0);
        chk("rd_to8_done", d0_to, 1'b0);
        chk("rd_data8", d0_bus_data, HAS_DTACK ? 16'h00FF : 16'h0034);
        wait_neg(3);
        chk("rd_oe16_held", d1_oe, 1'b1);
        cs_n = 1'b1;
        wait_neg(4);
        chk("rd_oe16_off", d1_oe, 1'b0);    chk("rd_dtack16_off", d1_dtack, 1'b1);

        // Glitch: CS low for one sampled cycle
        cs_n = 1'b0; rnw = 1'b0;
        wait_neg(1);
        cs_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("gl_ws8", d0_ws, 1'b0);   chk("gl_rs16", d1_rs, 1'b0);
            chk("gl_dtack8", d0_dtack, 1'b1);
        end

        // Abort during read wait, then a late ack that must be ignored
        cs_n = 1'b0; rnw = 1'b1; addr = 5'b00011;
        wait_neg(2);
        cs_n = 1'b1;
        wait_rs(ok);
        chk("ab_oe16_on", d1_oe, 1'b1);
        wait_neg(1);
        chk("ab_oe16_off", d1_oe, 1'b0);    chk("ab_oe8_off", d0_oe, 1'b0);
        chk("ab_dtack16", d1_dtack, 1'b1);
        wait_neg(2);
        rd_ack = 1'b1; rd_data = 16'hBEEF;
        wait_neg(1);
        rd_ack = 1'b0;
        wait_neg(1);
        chk("late_ack16", d1_bus_data, 16'h1234);
        chk("late_ack8", d0_bus_data, HAS_DTACK ? 16'h00FF : 16'h0034);
        chk("late_dtack16", d1_dtack, 1'b1);

        // Reset while both bridges sit in HOLD on a read
        cs_n = 1'b0; rnw = 1'b1; addr = 5'b01100;
        wait_rs(ok);
        wait_neg(1);
        rd_ack = 1'b1; rd_data = 16'hC3C3;
        wait_neg(1);
        rd_ack = 1'b0;
        chk("hold_oe16", d1_oe, 1'b1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rsth_dtack16", d1_dtack, 1'b1); chk("rsth_oe16", d1_oe, 1'b0);
        chk("rsth_dtack8", d0_dtack, 1'b1);  chk("rsth_oe8", d0_oe, 1'b0);
        chk("rsth_rd16", d1_bus_data, 16'h0000);
        cs_n = 1'b1;
        wait_neg(2);
        reset_n = 1'b1;
        wait_neg(3);

        // Randomized traffic
        for (int seg = 0; seg < 400; seg++) begin
            int len;
            len   = $urandom_range(1, 12);
            cs_n  = 1'($urandom_range(0, 1));
            rnw   = 1'($urandom_range(0, 1));
            addr  = 5'($urandom);
            wdata = 16'($urandom);
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                rd_ack  = ($urandom_range(0, 4) == 0);
                rd_data = 16'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    addr  = 5'($urandom);
                    wdata = 16'($urandom);
                end
            end
            if ($urandom_range(0, 59) == 0) begin
                #2 reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end
        end
        cs_n = 1'b1; rd_ack = 1'b0;
        wait_neg(10);
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
